ifetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction register. On request from the control unit it reads one 16-bit word from instruction memory over a req/ack handshake, presents it on `ir_data` and pulses `ir_wr` for exactly one cycle so the instruction register captures it on the following rising edge. It owns the program counter, which auto-increments per fetch and can be overwritten by a jump.

---
 rtl/ifetch_unit_if.sv | 25 ++
 rtl/ifetch_unit.sv | 171 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction memory read bus between fetch stage and memory.
// The fetch unit drives req/addr; memory answers with ack/data.
interface ifetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetches one instruction word per request and owns the PC.
// Define IFETCH_PREFETCH_EN to add a one-entry sequential prefetch buffer.
module ifetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 DATA_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_start,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    ifetch_unit_if.master     im,
    output logic [DATA_W-1:0] ir_data,
    output logic              ir_wr,
    output logic              fetch_done,
    output logic              busy,
    output logic [ADDR_W-1:0] pc
);

`ifdef IFETCH_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, REQ, LOAD, PREF} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;
`endif

    state_t            state;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] ir_q;
    logic              wr_q;
    logic              busy_q;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
`ifdef IFETCH_PREFETCH_EN
    logic [DATA_W-1:0] buf_data;
    logic              buf_vld;
    logic              pf_start;
    logic              pf_drop;
`endif

    assign pc_inc     = pc_q + 1'b1;
    assign im.req     = req_q;
    assign im.addr    = addr_q;
    assign ir_data    = ir_q;
    assign ir_wr      = wr_q;
    assign fetch_done = wr_q;
    assign busy       = busy_q;
    assign pc         = pc_q;

    // Fetch FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
`ifdef IFETCH_PREFETCH_EN
            buf_data  <= '0;
            buf_vld   <= 1'b0;
            pf_start  <= 1'b0;
            pf_drop   <= 1'b0;
`endif
        end else begin
            wr_q <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            // A jump makes any buffered sequential word stale.
            if (jump_en) buf_vld <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (jump_en) begin
                        pc_q   <= jump_addr;
                        addr_q <= jump_addr;
                    end
                    if (fetch_start) begin
`ifdef IFETCH_PREFETCH_EN
                        if (buf_vld && !jump_en) begin
                            ir_q    <= buf_data;
                            buf_vld <= 1'b0;
                            wr_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            state   <= LOAD;
                        end else
`endif
                        begin
                            req_q  <= 1'b1;
                            busy_q <= 1'b1;
                            state  <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (jump_en) begin
                        pend_vld  <= 1'b1;
                        pend_addr <= jump_addr;
                    end
                    if (im.ack) begin
                        req_q <= 1'b0;
                        ir_q  <= im.data;
                        wr_q  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    pend_vld <= 1'b0;
                    if (jump_en) begin
                        pc_q   <= jump_addr;
                        addr_q <= jump_addr;
                    end else if (pend_vld) begin
                        pc_q   <= pend_addr;
                        addr_q <= pend_addr;
                    end else begin
                        pc_q   <= pc_inc;
                        addr_q <= pc_inc;
`ifdef IFETCH_PREFETCH_EN
                        req_q    <= 1'b1;
                        pf_start <= 1'b0;
                        pf_drop  <= 1'b0;
                        state    <= PREF;
`endif
                    end
                end
`ifdef IFETCH_PREFETCH_EN
                PREF: begin
                    if (jump_en) begin
                        pc_q    <= jump_addr;
                        pf_drop <= 1'b1;
                    end
                    if (fetch_start) pf_start <= 1'b1;
                    if (im.ack) begin
                        req_q  <= 1'b0;
                        addr_q <= jump_en ? jump_addr : pc_q;
                        state  <= IDLE;
                        if (pf_drop || jump_en) begin
                            if (pf_start || fetch_start) begin
                                req_q  <= 1'b1;
                                busy_q <= 1'b1;
                                state  <= REQ;
                            end
                        end else if (pf_start || fetch_start) begin
                            ir_q   <= im.data;
                            wr_q   <= 1'b1;
                            busy_q <= 1'b1;
                            state  <= LOAD;
                        end else begin
                            buf_data <= im.data;
                            buf_vld  <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    req_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of the fetch handshake, PC and jumps.
// A second instance with RESET_PC=0xFFFF covers PC wrap-around.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start, jump_en;
    logic [15:0] jump_addr;
    logic [15:0] ir_data, pc;
    logic        ir_wr, fetch_done, busy;
    logic        fs2, je2;
    logic [15:0] ja2, ir_data2, pc2;
    logic        ir_wr2, fd2, busy2;
    int          vecs = 0;
    int          errs = 0;

    ifetch_unit_if #(.ADDR_W(16), .DATA_W(16)) im_bus ();
    ifetch_unit_if #(.ADDR_W(16), .DATA_W(16)) im_bus2 ();

    ifetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start),
        .jump_en(jump_en), .jump_addr(jump_addr), .im(im_bus.master),
        .ir_data(ir_data), .ir_wr(ir_wr), .fetch_done(fetch_done),
        .busy(busy), .pc(pc)
    );

    ifetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .fetch_start(fs2),
        .jump_en(je2), .jump_addr(ja2), .im(im_bus2.master),
        .ir_data(ir_data2), .ir_wr(ir_wr2), .fetch_done(fd2),
        .busy(busy2), .pc(pc2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_start = 1'b0; jump_en = 1'b0; jump_addr = 16'h0;
        fs2 = 1'b0; je2 = 1'b0; ja2 = 16'h0;
        im_bus.ack = 1'b0; im_bus.data = 16'h0;
        im_bus2.ack = 1'b0; im_bus2.data = 16'h0;
        step(); step();
        vecs++; if (im_bus.req !== 1'b0) begin errs++; $display("FAIL rst_req got %h exp 0", im_bus.req); end
        vecs++; if (im_bus.addr !== 16'h0000) begin errs++; $display("FAIL rst_addr got %h exp 0000", im_bus.addr); end
        vecs++; if (pc !== 16'h0000) begin errs++; $display("FAIL rst_pc got %h exp 0000", pc); end
        vecs++; if (ir_data !== 16'h0000) begin errs++; $display("FAIL rst_ir got %h exp 0000", ir_data); end
        vecs++; if (ir_wr !== 1'b0 || fetch_done !== 1'b0) begin errs++; $display("FAIL rst_wr got %b%b exp 00", ir_wr, fetch_done); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %h exp 0", busy); end
        vecs++; if (pc2 !== 16'hFFFF || im_bus2.addr !== 16'hFFFF) begin errs++; $display("FAIL rst_pc2 got %h/%h exp ffff", pc2, im_bus2.addr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        im_bus.ack = 1'b1; im_bus.data = 16'hA5C3;
        step(); step();
        vecs++; if (ir_wr !== 1'b0 || im_bus.req !== 1'b0) begin errs++; $display("FAIL idle_ack got wr=%b req=%b exp 0/0", ir_wr, im_bus.req); end
        fetch_start = 1'b1; im_bus.ack = 1'b0;
        step();
        fetch_start = 1'b0; im_bus.ack = 1'b1;
        vecs++; if (im_bus.req !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL basic_req got req=%b busy=%b exp 1/1", im_bus.req, busy); end
        vecs++; if (im_bus.addr !== 16'h0000) begin errs++; $display("FAIL basic_addr got %h exp 0000", im_bus.addr); end
        step();
        im_bus.ack = 1'b0;
        vecs++; if (ir_wr !== 1'b1 || fetch_done !== 1'b1) begin errs++; $display("FAIL basic_wr got %b%b exp 11", ir_wr, fetch_done); end
        vecs++; if (ir_data !== 16'hA5C3) begin errs++; $display("FAIL basic_data got %h exp a5c3", ir_data); end
        vecs++; if (im_bus.req !== 1'b0) begin errs++; $display("FAIL basic_req_drop got %h exp 0", im_bus.req); end
        step();
        vecs++; if (ir_wr !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL basic_end got wr=%b busy=%b exp 0/0", ir_wr, busy); end
        vecs++; if (pc !== 16'h0001) begin errs++; $display("FAIL basic_pc got %h exp 0001", pc); end
        vecs++; if (ir_data !== 16'hA5C3) begin errs++; $display("FAIL basic_hold got %h exp a5c3", ir_data); end
    endtask

    task automatic test_wait_states();
        int wr_cnt = 0;
        fetch_start = 1'b1; im_bus.ack = 1'b0; im_bus.data = 16'h1234;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (ir_wr === 1'b1) wr_cnt++;
            vecs++; if (im_bus.req !== 1'b1 || im_bus.addr !== 16'h0001) begin errs++; $display("FAIL wait_stable[%0d] got req=%b addr=%h exp 1/0001", i, im_bus.req, im_bus.addr); end
        end
        im_bus.ack = 1'b1;
        step();
        im_bus.ack = 1'b0;
        if (ir_wr === 1'b1) wr_cnt++;
        vecs++; if (fetch_done !== ir_wr || ir_data !== 16'h1234) begin errs++; $display("FAIL wait_load got done=%b wr=%b data=%h exp 1/1/1234", fetch_done, ir_wr, ir_data); end
        step();
        if (ir_wr === 1'b1) wr_cnt++;
        vecs++; if (wr_cnt !== 1) begin errs++; $display("FAIL wait_wr_count got %0d exp 1", wr_cnt); end
        vecs++; if (pc !== 16'h0002) begin errs++; $display("FAIL wait_pc got %h exp 0002", pc); end
    endtask

    task automatic test_jump();
        jump_en = 1'b1; jump_addr = 16'h0100; fetch_start = 1'b1;
        step();
        jump_en = 1'b0; fetch_start = 1'b0;
        vecs++; if (im_bus.addr !== 16'h0100 || pc !== 16'h0100) begin errs++; $display("FAIL jidle_addr got addr=%h pc=%h exp 0100", im_bus.addr, pc); end
        im_bus.ack = 1'b1; im_bus.data = 16'hBEEF;
        step();
        im_bus.ack = 1'b0;
        step();
        vecs++; if (pc !== 16'h0101) begin errs++; $display("FAIL jidle_pc got %h exp 0101", pc); end
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; jump_en = 1'b1; jump_addr = 16'h0200;
        step();
        jump_en = 1'b0;
        vecs++; if (im_bus.addr !== 16'h0101 || pc !== 16'h0101) begin errs++; $display("FAIL jreq_stable got addr=%h pc=%h exp 0101", im_bus.addr, pc); end
        im_bus.ack = 1'b1;
        step();
        im_bus.ack = 1'b0;
        step();
        vecs++; if (pc !== 16'h0200 || im_bus.addr !== 16'h0200) begin errs++; $display("FAIL jreq_pc got pc=%h addr=%h exp 0200", pc, im_bus.addr); end
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0; jump_en = 1'b1; jump_addr = 16'h0300;
        step();
        jump_addr = 16'h0500; im_bus.ack = 1'b1;
        step();
        jump_en = 1'b0; im_bus.ack = 1'b0;
        step();
        vecs++; if (pc !== 16'h0500) begin errs++; $display("FAIL jlast_pc got %h exp 0500", pc); end
    endtask

    task automatic test_busy_drop();
        int wr_cnt = 0;
        fetch_start = 1'b1;
        step();
        step();
        fetch_start = 1'b0; im_bus.ack = 1'b1; im_bus.data = 16'h7777;
        step();
        if (ir_wr === 1'b1) wr_cnt++;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ir_wr === 1'b1) wr_cnt++;
        end
        im_bus.ack = 1'b0;
        vecs++; if (wr_cnt !== 1) begin errs++; $display("FAIL drop_wr_count got %0d exp 1", wr_cnt); end
        vecs++; if (pc !== 16'h0501 || im_bus.req !== 1'b0) begin errs++; $display("FAIL drop_pc got pc=%h req=%b exp 0501/0", pc, im_bus.req); end
    endtask

    task automatic test_wrap();
        fs2 = 1'b1;
        step();
        fs2 = 1'b0;
        vecs++; if (im_bus2.addr !== 16'hFFFF || im_bus2.req !== 1'b1) begin errs++; $display("FAIL wrap_addr got %h req=%b exp ffff/1", im_bus2.addr, im_bus2.req); end
        im_bus2.ack = 1'b1; im_bus2.data = 16'h4242;
        step();
        im_bus2.ack = 1'b0;
        vecs++; if (ir_wr2 !== 1'b1 || ir_data2 !== 16'h4242) begin errs++; $display("FAIL wrap_load got wr=%b data=%h exp 1/4242", ir_wr2, ir_data2); end
        step();
        vecs++; if (pc2 !== 16'h0000) begin errs++; $display("FAIL wrap_pc got %h exp 0000", pc2); end
    endtask

    task automatic test_reset_abort();
        int wr_cnt = 0;
        fetch_start = 1'b1; im_bus.ack = 1'b0;
        step();
        fetch_start = 1'b0;
        step();
        vecs++; if (im_bus.req !== 1'b1) begin errs++; $display("FAIL abort_pre got %h exp 1", im_bus.req); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (im_bus.req !== 1'b0 || pc !== 16'h0000 || busy !== 1'b0) begin errs++; $display("FAIL abort_now got req=%b pc=%h busy=%b exp 0/0000/0", im_bus.req, pc, busy); end
        step();
        rst_n = 1'b1; im_bus.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (ir_wr === 1'b1) wr_cnt++;
        end
        im_bus.ack = 1'b0;
        vecs++; if (wr_cnt !== 0 || im_bus.req !== 1'b0) begin errs++; $display("FAIL abort_late got wr=%0d req=%b exp 0/0", wr_cnt, im_bus.req); end
    endtask

`ifdef IFETCH_PREFETCH_EN
    task automatic test_prefetch();
        fetch_start = 1'b1; im_bus.ack = 1'b0; im_bus.data = 16'h1111;
        step();
        fetch_start = 1'b0; im_bus.ack = 1'b1;
        step();
        im_bus.ack = 1'b0; im_bus.data = 16'h2222;
        step();
        vecs++; if (im_bus.req !== 1'b1 || im_bus.addr !== 16'h0001 || busy !== 1'b0) begin errs++; $display("FAIL pf_issue got req=%b addr=%h busy=%b exp 1/0001/0", im_bus.req, im_bus.addr, busy); end
        im_bus.ack = 1'b1;
        step();
        im_bus.ack = 1'b0; im_bus.data = 16'h9999;
        vecs++; if (im_bus.req !== 1'b0) begin errs++; $display("FAIL pf_done got %h exp 0", im_bus.req); end
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        vecs++; if (ir_wr !== 1'b1 || ir_data !== 16'h2222 || im_bus.req !== 1'b0) begin errs++; $display("FAIL pf_hit got wr=%b data=%h req=%b exp 1/2222/0", ir_wr, ir_data, im_bus.req); end
        step();
        jump_en = 1'b1; jump_addr = 16'h0300;
        step();
        jump_en = 1'b0; im_bus.ack = 1'b1;
        step();
        im_bus.ack = 1'b0; im_bus.data = 16'h3333;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        vecs++; if (ir_wr !== 1'b0 || im_bus.req !== 1'b1 || im_bus.addr !== 16'h0300) begin errs++; $display("FAIL pf_jump got wr=%b req=%b addr=%h exp 0/1/0300", ir_wr, im_bus.req, im_bus.addr); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef IFETCH_PREFETCH_EN
        test_prefetch();
`else
        test_basic();
        test_wait_states();
        test_jump();
        test_busy_drop();
        test_reset_abort();
`endif
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
